// File: rtl/fix_serializer_if.sv
// Field-in / byte-out bundle for fix_serializer.
// slave is the serializer side, master is the producer/line side.
interface fix_serializer_if;
    logic [31:0]  tag_i;
    logic [255:0] value_i;
    logic         last_i;
    logic         valid_i;
    logic         ready_o;
    logic [7:0]   data_o;
    logic         data_valid_o;
    logic         data_ready_i;
    logic         sof_o;
    logic         eom_o;

    modport master (
        output tag_i, value_i, last_i, valid_i, data_ready_i,
        input  ready_o, data_o, data_valid_o, sof_o, eom_o
    );

    modport slave (
        input  tag_i, value_i, last_i, valid_i, data_ready_i,
        output ready_o, data_o, data_valid_o, sof_o, eom_o
    );
endinterface

// File: rtl/fix_serializer.sv
// FIX field serializer: emits |tag=value| per field into a byte stream.
// Define FIX_SER_CHECKSUM_EN to append the 10=NNN| checksum trailer.
module fix_serializer #(
    parameter logic [7:0] DELIM = 8'h7c
) (
    input  logic            clk,
    input  logic            rst,
    fix_serializer_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, LEAD, TAG, EQ, VAL, DLM, CK_TAG, CK_DIG, CK_DLM
    } state_t;

    // State names the byte currently held in the output register.
    state_t       state_q, state_d;
    logic [31:0]  tag_q, tag_d;
    logic [255:0] val_q, val_d;
    logic         last_q, last_d;
    logic         first_q, first_d;
    logic [2:0]   tcnt_q, tcnt_d;
    logic [5:0]   vcnt_q, vcnt_d;
    logic [7:0]   data_q, data_d;
    logic         dv_q, dv_d;
    logic         sof_q, sof_d;
    logic         eom_q, eom_d;

    logic         fire, accept, ld, stop, nsof, neom, dlm_eom;
    logic [7:0]   nb;

`ifdef FIX_SER_CHECKSUM_EN
    logic [1:0]      idx_q, idx_d;
    logic [7:0]      acc_q, acc_d;
    logic [3:0][7:0] dig;
    logic            body;

    assign dig[0]  = 8'h30 + acc_q / 8'd100;
    assign dig[1]  = 8'h30 + (acc_q / 8'd10) % 8'd10;
    assign dig[2]  = 8'h30 + acc_q % 8'd10;
    assign dig[3]  = 8'h00;
    assign dlm_eom = 1'b0;
`else
    assign dlm_eom = last_q;
`endif

    assign fire             = dv_q & bus.data_ready_i;
    assign bus.ready_o      = (state_q == IDLE) & ~rst;
    assign accept           = bus.valid_i & bus.ready_o;
    assign bus.data_o       = data_q;
    assign bus.data_valid_o = dv_q;
    assign bus.sof_o        = sof_q;
    assign bus.eom_o        = eom_q;

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        val_d   = val_q;
        last_d  = last_q;
        first_d = first_q;
        tcnt_d  = tcnt_q;
        vcnt_d  = vcnt_q;
        data_d  = data_q;
        dv_d    = dv_q;
        sof_d   = sof_q;
        eom_d   = eom_q;
        ld      = 1'b0;
        stop    = 1'b0;
        nsof    = 1'b0;
        neom    = 1'b0;
        nb      = 8'h00;
`ifdef FIX_SER_CHECKSUM_EN
        idx_d   = idx_q;
        acc_d   = acc_q;
`endif
        unique case (state_q)
            IDLE: if (accept) begin
                val_d  = bus.value_i;
                last_d = bus.last_i;
                if (bus.tag_i[31:24] == 8'h00) begin
                    // Dropped field: nothing emitted, but it may close the message.
                    if (bus.last_i) first_d = 1'b1;
                end else if (first_q) begin
                    tag_d   = bus.tag_i;
                    nb      = DELIM;
                    nsof    = 1'b1;
                    ld      = 1'b1;
                    first_d = 1'b0;
                    state_d = LEAD;
                end else begin
                    tag_d   = bus.tag_i << 8;
                    tcnt_d  = 3'd1;
                    nb      = bus.tag_i[31:24];
                    ld      = 1'b1;
                    state_d = TAG;
                end
            end
            LEAD: if (fire) begin
                nb      = tag_q[31:24];
                tag_d   = tag_q << 8;
                tcnt_d  = 3'd1;
                ld      = 1'b1;
                state_d = TAG;
            end
            TAG: if (fire) begin
                ld = 1'b1;
                if (tcnt_q == 3'd4 || tag_q[31:24] == 8'h00) begin
                    nb      = 8'h3d;
                    state_d = EQ;
                end else begin
                    nb     = tag_q[31:24];
                    tag_d  = tag_q << 8;
                    tcnt_d = tcnt_q + 3'd1;
                end
            end
            EQ, VAL: if (fire) begin
                ld = 1'b1;
                if ((state_q == VAL && vcnt_q == 6'd32) ||
                    val_q[255:248] == 8'h00) begin
                    nb      = DELIM;
                    neom    = dlm_eom;
                    state_d = DLM;
                end else begin
                    nb      = val_q[255:248];
                    val_d   = val_q << 8;
                    vcnt_d  = (state_q == EQ) ? 6'd1 : vcnt_q + 6'd1;
                    state_d = VAL;
                end
            end
            DLM: if (fire) begin
`ifdef FIX_SER_CHECKSUM_EN
                if (last_q) begin
                    nb      = 8'h31;
                    ld      = 1'b1;
                    idx_d   = 2'd1;
                    state_d = CK_TAG;
                end else begin
                    stop    = 1'b1;
                    state_d = IDLE;
                end
`else
                stop    = 1'b1;
                first_d = last_q;
                state_d = IDLE;
`endif
            end
`ifdef FIX_SER_CHECKSUM_EN
            CK_TAG: if (fire) begin
                ld = 1'b1;
                if (idx_q != 2'd3) begin
                    nb    = (idx_q == 2'd1) ? 8'h30 : 8'h3d;
                    idx_d = idx_q + 2'd1;
                end else begin
                    nb      = dig[0];
                    idx_d   = 2'd1;
                    state_d = CK_DIG;
                end
            end
            CK_DIG: if (fire) begin
                ld = 1'b1;
                if (idx_q != 2'd3) begin
                    nb    = dig[idx_q];
                    idx_d = idx_q + 2'd1;
                end else begin
                    nb      = DELIM;
                    neom    = 1'b1;
                    state_d = CK_DLM;
                end
            end
            CK_DLM: if (fire) begin
                stop    = 1'b1;
                first_d = 1'b1;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        if (ld) begin
            data_d = nb;
            dv_d   = 1'b1;
            sof_d  = nsof;
            eom_d  = neom;
        end else if (stop) begin
            data_d = 8'h00;
            dv_d   = 1'b0;
            sof_d  = 1'b0;
            eom_d  = 1'b0;
        end
`ifdef FIX_SER_CHECKSUM_EN
        // Body bytes are those loaded while building a field, never the lead.
        body = ld & ~nsof &
               (state_q == IDLE || state_q == LEAD || state_q == TAG ||
                state_q == EQ || state_q == VAL);
        if (ld && nsof) acc_d = 8'h00;
        else if (body)  acc_d = acc_q + nb;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tag_q   <= '0;
            val_q   <= '0;
            last_q  <= 1'b0;
            first_q <= 1'b1;
            tcnt_q  <= '0;
            vcnt_q  <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            sof_q   <= 1'b0;
            eom_q   <= 1'b0;
`ifdef FIX_SER_CHECKSUM_EN
            idx_q   <= '0;
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            val_q   <= val_d;
            last_q  <= last_d;
            first_q <= first_d;
            tcnt_q  <= tcnt_d;
            vcnt_q  <= vcnt_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            sof_q   <= sof_d;
            eom_q   <= eom_d;
`ifdef FIX_SER_CHECKSUM_EN
            idx_q   <= idx_d;
            acc_q   <= acc_d;
`endif
        end
    end
endmodule

// File: tb/tb_fix_serializer.sv
// Directed bench for fix_serializer: table of messages plus
// hand-written reset, zero-tag and stall sequences.
module tb_fix_serializer;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    fix_serializer_if bus();

    fix_serializer #(.DELIM(8'h7c)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int                nf;
        logic [2:0][31:0]  tag;
        logic [2:0][255:0] val;
        logic [2:0]        last;
        bit                stall;
        logic [511:0]      exp;
        int                len;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lt32(input logic [31:0] x);
        logic [31:0] r;
        r = x;
        for (int i = 0; i < 4; i++)
            if (r != 0 && r[31:24] == 8'h00) r = r << 8;
        return r;
    endfunction

    function automatic logic [255:0] lt256(input logic [255:0] x);
        logic [255:0] r;
        r = x;
        for (int i = 0; i < 32; i++)
            if (r != 0 && r[255:248] == 8'h00) r = r << 8;
        return r;
    endfunction

    function automatic int slen(input logic [511:0] s);
        for (int i = 63; i >= 0; i--)
            if (s[8*i +: 8] != 8'h00) return i + 1;
        return 0;
    endfunction

    task automatic drive(input int v, input int f);
        bus.tag_i   = vecs[v].tag[f];
        bus.value_i = vecs[v].val[f];
        bus.last_i  = vecs[v].last[f];
        bus.valid_i = 1'b1;
    endtask

    task automatic run_vec(input int v);
        int         fi, nb, cyc, len;
        bit         busy, acc, stalled, lat;
        logic [7:0] prev, eb;
        logic       psof, peom;
        fi = 0; nb = 0; cyc = 0; busy = 0;
        acc = 0; stalled = 0; lat = 0;
        prev = 8'h00; psof = 0; peom = 0;
        len = vecs[v].len;
        bus.data_ready_i = vecs[v].stall ? 1'($urandom_range(0, 1)) : 1'b1;
        drive(v, 0);
        while ((fi < vecs[v].nf || nb < len) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (lat) chk("first_byte_latency", bus.data_valid_o, 1);
            if (stalled) begin
                chk("hold_data", bus.data_o, prev);
                chk("hold_valid", bus.data_valid_o, 1);
                chk("hold_sof", bus.sof_o, psof);
                chk("hold_eom", bus.eom_o, peom);
            end
            if (busy) chk("ready_low_in_field", bus.ready_o, 0);
            acc = bus.valid_i && bus.ready_o;
            if (bus.data_valid_o && bus.data_ready_i) begin
                if (nb >= len) begin
                    chk("extra_byte", bus.data_o, 0);
                end else begin
                    eb = vecs[v].exp[8*(len-1-nb) +: 8];
                    chk("byte", bus.data_o, eb);
                    chk("sof", bus.sof_o, (nb == 0) ? 1 : 0);
                    chk("eom", bus.eom_o, (nb == len - 1) ? 1 : 0);
                    if (nb > 0 && eb == 8'h7c) busy = 0;
                end
                nb++;
            end
            stalled = bus.data_valid_o && !bus.data_ready_i;
            prev = bus.data_o;
            psof = bus.sof_o;
            peom = bus.eom_o;
            @(posedge clk);
            #1;
            lat = acc;
            if (acc) begin
                busy = 1;
                fi++;
                if (fi < vecs[v].nf) drive(v, fi);
                else bus.valid_i = 1'b0;
            end
            bus.data_ready_i = vecs[v].stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (cyc >= 3000) chk("timeout", 1, 0);
        bus.valid_i = 1'b0;
        bus.data_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_msg", bus.data_valid_o, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0].nf = 1;
        vecs[0].tag[0] = lt32("35");
        vecs[0].val[0] = lt256("8");
        vecs[0].last = 3'b001;
        vecs[0].stall = 0;

        vecs[1].nf = 3;
        vecs[1].tag[0] = lt32("8");
        vecs[1].val[0] = lt256("FIX.4.2");
        vecs[1].tag[1] = lt32("9");
        vecs[1].val[1] = lt256("178");
        vecs[1].tag[2] = lt32("35");
        vecs[1].val[2] = lt256("8");
        vecs[1].last = 3'b100;
        vecs[1].stall = 0;

        vecs[2].nf = 1;
        vecs[2].tag[0] = lt32("1234");
        vecs[2].val[0] = "ABCDEFGHIJKLMNOPQRSTUVWXYZ012345";
        vecs[2].last = 3'b001;
        vecs[2].stall = 0;

        vecs[3] = vecs[1];
        vecs[3].stall = 1;

        vecs[4].nf = 1;
        vecs[4].tag[0] = lt32("58");
        vecs[4].val[0] = '0;
        vecs[4].last = 3'b001;
        vecs[4].stall = 0;

`ifdef FIX_SER_CHECKSUM_EN
        vecs[0].exp = "|35=8|10=089|";
        vecs[1].exp = "|8=FIX.4.2|9=178|35=8|10=133|";
        vecs[2].exp = "|1234=ABCDEFGHIJKLMNOPQRSTUVWXYZ012345|10=145|";
        vecs[4].exp = "|58=|10=038|";
`else
        vecs[0].exp = "|35=8|";
        vecs[1].exp = "|8=FIX.4.2|9=178|35=8|";
        vecs[2].exp = "|1234=ABCDEFGHIJKLMNOPQRSTUVWXYZ012345|";
        vecs[4].exp = "|58=|";
`endif
        vecs[3].exp = vecs[1].exp;
        for (int i = 0; i < 5; i++) vecs[i].len = slen(vecs[i].exp);

        rst = 1'b1;
        bus.tag_i = '0;
        bus.value_i = '0;
        bus.last_i = 1'b0;
        bus.valid_i = 1'b0;
        bus.data_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_data", bus.data_o, 0);
        chk("rst_valid", bus.data_valid_o, 0);
        chk("rst_sof", bus.sof_o, 0);
        chk("rst_eom", bus.eom_o, 0);
        chk("rst_ready", bus.ready_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", bus.ready_o, 1);
        @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) run_vec(v);

        // Zero tag: dropped, no bytes, ready again next cycle.
        bus.tag_i = '0;
        bus.value_i = lt256("X");
        bus.last_i = 1'b0;
        bus.valid_i = 1'b1;
        @(negedge clk);
        chk("zero_tag_ready", bus.ready_o, 1);
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
        @(negedge clk);
        chk("zero_tag_ready_next", bus.ready_o, 1);
        chk("zero_tag_no_byte", bus.data_valid_o, 0);
        @(negedge clk);
        chk("zero_tag_still_idle", bus.data_valid_o, 0);
        @(posedge clk);
        #1;
        run_vec(0);

        // Reset pulse while the value is streaming.
        bus.tag_i = lt32("8");
        bus.value_i = lt256("FIX.4.2");
        bus.last_i = 1'b0;
        bus.valid_i = 1'b1;
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_val_byte", bus.data_o, 8'h46);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready_low", bus.ready_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_data", bus.data_o, 0);
        chk("midrst_valid", bus.data_valid_o, 0);
        chk("midrst_sof", bus.sof_o, 0);
        chk("midrst_eom", bus.eom_o, 0);
        chk("midrst_ready", bus.ready_o, 1);
        @(negedge clk);
        chk("midrst_no_trailer", bus.data_valid_o, 0);
        @(posedge clk);
        #1;
        run_vec(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fix_serializer.md
# fix_serializer

Transmit-side counterpart of `fix_parser_top`. It accepts one FIX field per handshake as packed ASCII tag/value words, in the same layout the parser produces: `tag_o[31:0]` and `value_o[255:0]`. It emits a byte stream framed the way the parser consumes it: a leading delimiter, `tag=value|` per field, then an optional `10=NNN|` checksum trailer. The block sits between the order-generation logic and the byte-wide line interface, and can be looped directly into `fix_parser_top.data_i` for self-test.

## Interface
- `DELIM`, default `8'h7c` (`|`): field delimiter byte.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `tag_i`  in  32  tag ASCII, left-justified (`[31:24]` is the first char), padded with `8'h00`.
- `value_i`  in  256  value ASCII, left-justified (`[255:248]` is the first char), padded with `8'h00`.
- `last_i`  in  1  this field is the last body field of the message.
- `valid_i`  in  1  field valid.
- `ready_o`  out  1  field accepted when `valid_i & ready_o`.
- `data_o`  out  8  output byte.
- `data_valid_o`  out  1  `data_o` valid.
- `data_ready_i`  in  1  downstream takes the byte when `data_valid_o & data_ready_i`.
- `sof_o`  out  1  high with the leading delimiter byte of each message.
- `eom_o`  out  1  high with the final byte of each message.

## Operation
- FSM states: IDLE, LEAD, TAG, EQ, VAL, DLM, CK_TAG, CK_DIG, CK_DLM.
- IDLE (`ready_o=1`), on accept:
  - capture tag, value and last into shift registers;
  - go to LEAD if this is the first field of a message, else to TAG.
- LEAD: emits DELIM with `sof_o=1`. The checksum accumulator clears to 0.
- TAG: emits tag bytes MSB-first.
  - Stops at the first `8'h00` byte or after 4 bytes, then goes to EQ.
  - A tag whose first byte is `8'h00` is dropped with zero bytes emitted; the FSM returns to IDLE. A dropped field with `last_i=1` still ends the message.
- EQ: emits `=`.
- VAL: emits value bytes MSB-first, stopping at the first `8'h00` or after 32 bytes. An empty value emits no bytes.
- DLM: emits DELIM.
  - If last, go to CK_TAG (checksum enabled) or finish with `eom_o=1` on this byte.
  - Otherwise return to IDLE.
- Checksum trailer:
  - accumulator = 8-bit sum, mod 256, of every byte emitted after the leading delimiter, up to and including the DLM of the last field;
  - CK_TAG emits `1`, `0`, `=` (not summed);
  - CK_DIG emits 3 ASCII decimal digits, hundreds first, zero-padded;
  - CK_DLM emits DELIM with `eom_o=1`, then returns to IDLE with "first field" set.
- A byte advances only on `data_valid_o & data_ready_i`. While `data_ready_i=0`, `data_o`, `sof_o` and `eom_o` hold stable.

## Timing
- Output byte, `data_valid_o`, `sof_o` and `eom_o` are registered.
- The first byte of a field is valid the cycle after its accept.
- With `data_ready_i` held high, one byte is emitted per cycle.
- `ready_o` is combinational from state: high only in IDLE, and 0 while `rst` is high.
- Back-to-back fields: at most 1 bubble cycle between a DLM and the next field's first byte.
- Reset values:
  - `data_o=0`, `data_valid_o=0`, `sof_o=0`, `eom_o=0`;
  - state IDLE, "first field" set, accumulator 0.
- Reset asserted mid-message aborts immediately. Next cycle all outputs are at reset values and no partial trailer is emitted.
- `valid_i` while `ready_o=0` is ignored; the input must be held until accepted.

## Configuration
- `FIX_SER_CHECKSUM_EN`:
  - defined: CK_* states and accumulator are built and the trailer is appended;
  - undefined: the message ends at the last field's DLM, which carries `eom_o=1`, and the accumulator logic is absent.

## Test plan
- Single field, tag `"35"`, value `"8"`, last=1, `data_ready_i=1` -> exactly `|35=8|10=089|`. `sof_o` is high on byte 0 only; `eom_o` is high on the final `|` only.
- Three fields `8=FIX.4.2`, `9=178`, `35=8` (last) -> `|8=FIX.4.2|9=178|35=8|10=` followed by the mod-256 sum checked against the bench model. `ready_o` low throughout each field.
- Full-width value of 32 non-zero bytes with 4-char tag `"1234"` -> all 4+1+32+1 body bytes emitted, no truncation.
- `data_ready_i` toggled with a random 50% pattern on test 2 -> identical byte sequence; `data_o` stable while stalled.
- Empty value (tag `"58"`, value all zero) -> `58=|`. Zero tag -> no bytes, and `ready_o` returns high the next cycle.
- `rst` pulsed for 1 cycle mid-VAL -> outputs at reset values the next cycle. The next message starts with `sof_o` and a fresh checksum.
